// File: rtl/dcache_controller.sv
// Miss-handling controller for a 2-way, 16-set, 256-bit-line data cache.
// Hits are served combinationally. Misses write back a dirty victim, fetch the line, fill it, then retry.
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_memread_i,
  input  logic         cpu_memwrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [3:0]   sram_addr_o,
  output logic [24:0]  sram_tag_o,
  output logic [255:0] sram_data_o,
  output logic         sram_enable_o,
  output logic         sram_write_o,
  input  logic [24:0]  sram_tag_i,
  input  logic [255:0] sram_data_i,
  input  logic         sram_hit_i
);

  // Handshake: cpu_memread_i/cpu_memwrite_i form a request that the CPU holds
  // stable until a cycle with cpu_stall_o low, in which the access completes.
  // mem_enable_o is a one-cycle request; mem_ack_i is a one-cycle completion.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MISS      = 3'd1,
    WRITEBACK = 3'd2,
    FETCH     = 3'd3,
    REFILL    = 3'd4
  } state_t;

  state_t       state_q;
  logic [31:0]  wb_addr_q;
  logic [255:0] wb_data_q;
  logic         fetch_req_q;

  logic         req;
  logic         read_only;
  logic [22:0]  cpu_tag;
  logic [3:0]   index;
  logic [2:0]   word_sel;
  logic         victim_dirty;
  logic         lookup_state;
  logic         serve;
  logic         miss_now;
  logic [255:0] merged_line;
  logic         unused_byte_bits;

  assign req          = cpu_memread_i | cpu_memwrite_i;
  assign read_only    = cpu_memread_i & ~cpu_memwrite_i;
  assign cpu_tag      = cpu_addr_i[31:9];
  assign index        = cpu_addr_i[8:5];
  assign word_sel     = cpu_addr_i[4:2];
  assign victim_dirty = sram_tag_i[24] & sram_tag_i[23];
  assign unused_byte_bits = ^cpu_addr_i[1:0];

  // REFILL retries the lookup exactly like IDLE does.
  assign lookup_state = (state_q == IDLE) || (state_q == REFILL);
  assign serve        = lookup_state & req & sram_hit_i;
  assign miss_now     = lookup_state & req & ~sram_hit_i;

  always_comb begin
    merged_line = sram_data_i;
    merged_line[{word_sel, 5'b0} +: 32] = cpu_data_i;
  end

  always_comb begin
    cpu_data_o = 32'h0;
    if (serve && read_only)
      cpu_data_o = sram_data_i[{word_sel, 5'b0} +: 32];
    cpu_stall_o = miss_now || (state_q == MISS) || (state_q == WRITEBACK) ||
                  (state_q == FETCH);
  end

  always_comb begin
    sram_enable_o = req;
    sram_addr_o   = index;
    sram_tag_o    = {2'b00, cpu_tag};
    sram_data_o   = merged_line;
    sram_write_o  = 1'b0;
    if (serve && cpu_memwrite_i) begin
      sram_write_o = 1'b1;
      sram_tag_o   = {2'b11, cpu_tag};
    end else if (state_q == FETCH && mem_ack_i) begin
      sram_write_o = 1'b1;
      sram_data_o  = mem_data_i;
      sram_tag_o   = {2'b10, cpu_tag};
    end
  end

  // In MISS the victim comes straight from the lookup; afterwards the held copy is used.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = {cpu_tag, index, 5'b0};
    mem_data_o   = wb_data_q;
    case (state_q)
      MISS: begin
        mem_enable_o = 1'b1;
        if (victim_dirty) begin
          mem_write_o = 1'b1;
          mem_addr_o  = {sram_tag_i[22:0], index, 5'b0};
          mem_data_o  = sram_data_i;
        end
      end
      WRITEBACK: mem_addr_o = wb_addr_q;
      FETCH:     mem_enable_o = fetch_req_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wb_addr_q   <= 32'h0;
      wb_data_q   <= 256'h0;
      fetch_req_q <= 1'b0;
    end else begin
      fetch_req_q <= 1'b0;
      case (state_q)
        IDLE, REFILL: state_q <= miss_now ? MISS : IDLE;
        MISS: begin
          if (victim_dirty) begin
            wb_addr_q <= {sram_tag_i[22:0], index, 5'b0};
            wb_data_q <= sram_data_i;
            state_q   <= WRITEBACK;
          end else begin
            state_q <= FETCH;
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            fetch_req_q <= 1'b1;
            state_q     <= FETCH;
          end
        end
        FETCH:   if (mem_ack_i) state_q <= REFILL;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: a 2-way LRU SRAM and a latency-controlled memory surround the DUT.
// A flat word-level reference memory predicts every load result.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i, cpu_data_i;
  logic         cpu_memread_i, cpu_memwrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o, mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i, mem_ack_r, spur_ack;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic         sram_enable_o, sram_write_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;

  int n_checks = 0;
  int n_fail   = 0;
  int n_en     = 0;
  int mem_lat  = 1;

  logic [31:0] exp_q[$];
  logic [31:0] ref_w[logic [29:0]];
  logic [255:0] mem_l[logic [26:0]];
  logic         exp_wb_valid = 1'b0;
  logic [31:0]  exp_wb_addr, exp_fetch_addr, last_wb_addr;
  logic [255:0] exp_wb_data;

  always #5 clk_i = ~clk_i;
  assign mem_ack_i = mem_ack_r | spur_ack;

  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_memread_i(cpu_memread_i), .cpu_memwrite_i(cpu_memwrite_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i)
  );

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return {2'b00, wa} * 32'h9E3779B1 + 32'h0BADF00D;
  endfunction

  function automatic logic [31:0] get_ref(input logic [29:0] wa);
    if (ref_w.exists(wa)) return ref_w[wa];
    return init_word(wa);
  endfunction

  function automatic logic [255:0] get_line(input logic [26:0] la);
    logic [255:0] l;
    if (mem_l.exists(la)) return mem_l[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word({la, 3'(w)});
    return l;
  endfunction

  // ---------------- SRAM environment: 2 ways, LRU victim on miss ----------------
  logic         s_v[16][2], s_d[16][2], s_lru[16];
  logic [22:0]  s_t[16][2];
  logic [255:0] s_l[16][2];
  logic         env_ready = 1'b0;
  logic [3:0]   lk_idx;
  logic         lk_hit, lk_way;

  always_comb begin
    lk_idx = cpu_addr_i[8:5];
    lk_hit = 1'b0;
    lk_way = s_lru[lk_idx];
    for (int w = 0; w < 2; w++)
      if (s_v[lk_idx][w] && s_t[lk_idx][w] == cpu_addr_i[31:9]) begin
        lk_hit = 1'b1;
        lk_way = w[0];
      end
    sram_hit_i  = lk_hit;
    sram_tag_i  = {s_v[lk_idx][lk_way], s_d[lk_idx][lk_way], s_t[lk_idx][lk_way]};
    sram_data_i = s_l[lk_idx][lk_way];
  end

  always @(posedge clk_i) begin
    if (!env_ready) begin
      for (int i = 0; i < 16; i++) begin
        s_lru[i] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          s_v[i][w] <= 1'b0; s_d[i][w] <= 1'b0; s_t[i][w] <= '0; s_l[i][w] <= '0;
        end
      end
    end else if (!rst_i && sram_enable_o) begin
      if (sram_write_o) begin
        s_v[lk_idx][lk_way] <= sram_tag_o[24];
        s_d[lk_idx][lk_way] <= sram_tag_o[23];
        s_t[lk_idx][lk_way] <= sram_tag_o[22:0];
        s_l[lk_idx][lk_way] <= sram_data_o;
        s_lru[lk_idx]       <= ~lk_way;
      end else if (lk_hit) begin
        s_lru[lk_idx] <= ~lk_way;
      end
    end
  end

  // Every SRAM write is either a store hit (merged word, valid+dirty) or a fill (valid, clean).
  always @(negedge clk_i) begin
    logic [255:0] exp_line;
    if (!rst_i && sram_write_o) begin
      chk("sram_addr", 256'(sram_addr_o), 256'(cpu_addr_i[8:5]));
      chk("sram_tag_bits", 256'(sram_tag_o[22:0]), 256'(cpu_addr_i[31:9]));
      if (sram_hit_i) begin
        exp_line = sram_data_i;
        exp_line[cpu_addr_i[4:2]*32 +: 32] = cpu_data_i;
        chk("store_line", sram_data_o, exp_line);
        chk("store_vd", 256'(sram_tag_o[24:23]), 256'(2'b11));
        chk("store_is_write", 256'(cpu_memwrite_i), 256'(1'b1));
      end else begin
        chk("fill_on_ack", 256'(mem_ack_i), 256'(1'b1));
        chk("fill_line", sram_data_o, mem_data_i);
        chk("fill_vd", 256'(sram_tag_o[24:23]), 256'(2'b10));
      end
    end
  end

  // ---------------- memory environment ----------------
  always @(negedge clk_i) if (!rst_i && mem_enable_o) n_en++;

  initial begin
    logic [255:0] resp;
    mem_ack_r  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_i && mem_enable_o) begin
        if (mem_write_o) begin
          chk("wb_expected", 256'(exp_wb_valid), 256'(1'b1));
          chk("wb_addr", 256'(mem_addr_o), 256'(exp_wb_addr));
          chk("wb_data", mem_data_o, exp_wb_data);
          mem_l[mem_addr_o[31:5]] = mem_data_o;
          last_wb_addr = mem_addr_o;
          exp_wb_valid = 1'b0;
          resp = {8{$urandom}};
        end else begin
          chk("fetch_addr", 256'(mem_addr_o), 256'(exp_fetch_addr));
          resp = get_line(mem_addr_o[31:5]);
        end
        repeat (mem_lat) @(posedge clk_i);
        #1 mem_ack_r = 1'b1;
        mem_data_i = resp;
        @(posedge clk_i);
        #1 mem_ack_r = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk_i) begin
    logic [31:0] e;
    if (!rst_i) begin
      if (!cpu_memread_i && !cpu_memwrite_i) begin
        chk("idle_stall", 256'(cpu_stall_o), 256'(1'b0));
      end else if (!cpu_stall_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 256'(1'b1), 256'(1'b0));
        end else begin
          e = exp_q.pop_front();
          chk("cpu_data", 256'(cpu_data_o), 256'(e));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic access(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr,
                        input int lat, output logic [31:0] got, output int stalls);
    logic [3:0] idx;
    logic       hit, vic, dirty;
    int         exp_st, exp_en, en0;
    idx = a[8:5];
    hit = 1'b0;
    for (int w = 0; w < 2; w++) if (s_v[idx][w] && s_t[idx][w] == a[31:9]) hit = 1'b1;
    vic    = s_lru[idx];
    dirty  = s_v[idx][vic] && s_d[idx][vic];
    exp_st = hit ? 0 : (dirty ? 3 + 2 * lat : 2 + lat);
    exp_en = hit ? 0 : (dirty ? 2 : 1);
    exp_wb_valid   = !hit && dirty;
    exp_wb_addr    = {s_t[idx][vic], idx, 5'b0};
    exp_wb_data    = s_l[idx][vic];
    exp_fetch_addr = {a[31:5], 5'b0};
    mem_lat = lat;
    exp_q.push_back((rd && !wr) ? get_ref(a[31:2]) : 32'h0);
    en0 = n_en;
    @(posedge clk_i); #1;
    cpu_addr_i = a; cpu_data_i = d; cpu_memread_i = rd; cpu_memwrite_i = wr;
    stalls = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (!cpu_stall_o) break;
      stalls++;
      if (k == 99) chk("stall_timeout", 256'(1'b1), 256'(1'b0));
    end
    got = cpu_data_o;
    chk("stall_cycles", 256'(stalls), 256'(exp_st));
    chk("mem_requests", 256'(n_en - en0), 256'(exp_en));
    if (wr) ref_w[a[31:2]] = d;
    @(posedge clk_i); #1;
    cpu_memread_i = 1'b0; cpu_memwrite_i = 1'b0; cpu_data_i = $urandom;
  endtask

  initial begin
    logic [31:0]  got, a;
    logic [255:0] pre;
    int           st, op, en0;
    bit           seen;
    rst_i = 1'b1; spur_ack = 1'b0;
    cpu_addr_i = '0; cpu_data_i = '0; cpu_memread_i = 1'b0; cpu_memwrite_i = 1'b0;
    repeat (2) @(posedge clk_i);
    env_ready = 1'b1;
    @(negedge clk_i);
    chk("rst_stall", 256'(cpu_stall_o), 256'(1'b0));
    chk("rst_mem_en", 256'(mem_enable_o), 256'(1'b0));
    chk("rst_mem_we", 256'(mem_write_o), 256'(1'b0));
    chk("rst_sram_we", 256'(sram_write_o), 256'(1'b0));
    chk("rst_cpu_data", 256'(cpu_data_o), 256'(32'h0));
    rst_i = 1'b0;

    // cold clean miss on 0x48 with word2 of the line preloaded
    pre = get_line(27'h2);
    pre[95:64] = 32'hDEADBEEF;
    mem_l[27'h2] = pre;
    ref_w[30'h12] = 32'hDEADBEEF;
    access(32'h48, $urandom, 1, 0, 3, got, st);
    chk("cold_data_lit", 256'(got), 256'(32'hDEADBEEF));
    chk("cold_stall_lit", 256'(st), 256'(5));
    access(32'h48, $urandom, 1, 0, 2, got, st);
    chk("hit_stall_lit", 256'(st), 256'(0));

    // store hit then reload
    access(32'h44, 32'h12345678, 0, 1, 2, got, st);
    chk("store_hit_stall_lit", 256'(st), 256'(0));
    access(32'h44, $urandom, 1, 0, 2, got, st);
    chk("store_reload_lit", 256'(got), 256'(32'h12345678));

    // dirty eviction: tags 1 and 2 dirty in set 5, then tag 3
    access(32'h2A0, $urandom, 0, 1, 3, got, st);
    access(32'h4A4, $urandom, 0, 1, 3, got, st);
    access(32'h6A8, $urandom, 1, 0, 3, got, st);
    chk("dirty_stall_lit", 256'(st), 256'(9));
    chk("dirty_wb_addr_lit", 256'(last_wb_addr), 256'(32'h2A0));

    // clean eviction in set 6
    access(32'h2C0, $urandom, 1, 0, 2, got, st);
    access(32'h4C0, $urandom, 1, 0, 2, got, st);
    access(32'h6CC, $urandom, 1, 0, 2, got, st);
    chk("clean_evict_stall_lit", 256'(st), 256'(4));

    // simultaneous read and write behaves as a store
    access(32'h44, 32'hCAFEF00D, 1, 1, 2, got, st);
    chk("rw_data_zero_lit", 256'(got), 256'(32'h0));
    access(32'h44, $urandom, 1, 0, 2, got, st);
    chk("rw_reload_lit", 256'(got), 256'(32'hCAFEF00D));

    // spurious ack while idle
    @(posedge clk_i); #1 spur_ack = 1'b1;
    @(negedge clk_i);
    chk("spur_no_write", 256'(sram_write_o), 256'(1'b0));
    chk("spur_no_stall", 256'(cpu_stall_o), 256'(1'b0));
    @(posedge clk_i); #1 spur_ack = 1'b0;

    // reset while fetching: the late ack must not fill the SRAM
    mem_lat = 6; exp_fetch_addr = 32'h1000; en0 = n_en;
    @(posedge clk_i); #1;
    cpu_addr_i = 32'h1000; cpu_memread_i = 1'b1;
    for (int k = 0; k < 20 && n_en == en0; k++) @(negedge clk_i);
    chk("rst_test_fetch_seen", 256'(n_en - en0), 256'(1));
    @(posedge clk_i); #3;
    rst_i = 1'b1; cpu_memread_i = 1'b0;
    #1;
    chk("midrst_mem_en", 256'(mem_enable_o), 256'(1'b0));
    chk("midrst_sram_we", 256'(sram_write_o), 256'(1'b0));
    chk("midrst_stall", 256'(cpu_stall_o), 256'(1'b0));
    @(posedge clk_i); #1 rst_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk_i);
      if (mem_ack_i) begin
        seen = 1'b1;
        chk("late_ack_no_write", 256'(sram_write_o), 256'(1'b0));
        chk("late_ack_no_stall", 256'(cpu_stall_o), 256'(1'b0));
      end
    end
    chk("late_ack_seen", 256'(seen), 256'(1'b1));
    access(32'h1004, $urandom, 1, 0, 2, got, st);
    chk("post_rst_stall_lit", 256'(st), 256'(4));

    // randomized traffic over 4 tags x 4 sets
    for (int i = 0; i < 200; i++) begin
      a = 32'h0;
      a[10:9] = 2'($urandom_range(0, 3));
      a[6:5]  = 2'($urandom_range(0, 3));
      a[4:2]  = 3'($urandom_range(0, 7));
      op = $urandom_range(0, 4);
      access(a, $urandom, op < 2 || op == 4, op >= 2, $urandom_range(1, 4), got, st);
    end

    repeat (2) @(negedge clk_i);
    chk("exp_q_drained", 256'(exp_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Sequencing controller for the 2-way, 16-set, 256-bit-line data-cache SRAM.
- Accepts CPU word loads and stores, performs tag lookup through the SRAM's combinational hit path, and returns hit data in the same cycle.
- Handles misses: dirty-victim write-back, line fetch from main memory, fill, then retry.
- Sits between the CPU MEM stage and the off-chip memory model; stalls the pipeline while a miss is outstanding.

Parameters:
- None. Geometry is fixed: 32-bit address, tag [31:9] (23 b), index [8:5] (4 b), word offset [4:2], byte bits [1:0] ignored.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- cpu_addr_i  in  32  byte address of the access
- cpu_data_i  in  32  store data
- cpu_memread_i  in  1  load request; held until stall_o low
- cpu_memwrite_i  in  1  store request; held until stall_o low
- cpu_data_o  out  32  load data, valid when read and stall_o=0
- cpu_stall_o  out  1  pipeline stall
- mem_addr_o  out  32  line address to memory, low 5 bits zero
- mem_data_o  out  256  write-back line
- mem_enable_o  out  1  one-cycle memory request pulse
- mem_write_o  out  1  qualifies mem_enable_o: 1 = write, 0 = read
- mem_data_i  in  256  fetched line, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle completion pulse
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  {valid, dirty, tag[22:0]}
- sram_data_o  out  256  line to write
- sram_enable_o  out  1  SRAM access enable
- sram_write_o  out  1  SRAM write strobe
- sram_tag_i  in  25  hit way's tag, or LRU victim's tag on miss
- sram_data_i  in  256  hit way's line, or LRU victim's line on miss
- sram_hit_i  in  1  lookup hit

Behaviour:
- Request: req = cpu_memread_i | cpu_memwrite_i. If both are high, treat as a store; cpu_data_o = 0.
- Lookup drive: sram_enable_o = req; sram_addr_o = cpu_addr_i[8:5]; sram_tag_o[22:0] = cpu_addr_i[31:9].
- States: IDLE, MISS, WRITEBACK, FETCH, REFILL (3-bit encoded).
- IDLE, no request: stall 0.
- IDLE, read hit: cpu_data_o = sram_data_i word cpu_addr_i[4:2] (word 0 = bits [31:0]). Stall 0; zero-latency.
- IDLE, write hit: sram_write_o = 1. sram_data_o = sram_data_i with the addressed word replaced by cpu_data_i. sram_tag_o[24:23] = 2'b11. Stall 0; the write commits at the next clock edge.
- IDLE, miss: stall 1 combinationally; next state MISS.
- MISS, lasts one cycle:
  - Victim dirty (sram_tag_i[24] & sram_tag_i[23]): pulse mem_enable_o with mem_write_o = 1. mem_addr_o = {sram_tag_i[22:0], index, 5'b0}; mem_data_o = sram_data_i. Go to WRITEBACK.
  - Otherwise: pulse a read with mem_addr_o = {cpu tag, index, 5'b0}. Go to FETCH.
- Write-back data and address are registered in MISS and held stable until ack.
- WRITEBACK: wait for mem_ack_i. On ack, pulse a read of the requested line the next cycle and go to FETCH.
- FETCH: wait for mem_ack_i. On ack, in the same cycle:
  - sram_write_o = 1, sram_data_o = mem_data_i.
  - sram_tag_o = {1, 0, cpu tag}.
  - Go to REFILL.
- REFILL: lookup now hits; the hit path above applies (a store merges and sets dirty). Stall 0; go to IDLE.
- Miss penalty: 2 cycles plus memory latency for a clean victim; plus one write-back round trip for a dirty victim.
- Stall: cpu_stall_o = 1 in MISS, WRITEBACK and FETCH, and in IDLE on a miss.
- Spurious ack: mem_ack_i outside WRITEBACK/FETCH is ignored.
- The request must be held stable while stalled; a change mid-miss is unsupported.
- Reset, asynchronous: state = IDLE, all registered outputs 0. mem_enable_o, mem_write_o and sram_write_o are 0 immediately.
- Reset mid-miss abandons the transaction; a later ack is ignored.

Test Plan:
- Cold read miss, clean: reset, load 0x0000_0040. Expect mem read pulse, mem_addr_o = 0x0000_0040. Ack with line word2 = 0xDEADBEEF, then load 0x0000_0048 → cpu_data_o = 0xDEADBEEF, stall low in REFILL.
- Write hit: after fill, store 0x1234_5678 to 0x0000_0044 → sram_write_o = 1, word1 merged, tag[24:23] = 11, no stall. Reload → 0x1234_5678.
- Dirty eviction: dirty lines at tags 0x1 and 0x2 in set 2, LRU victim tag 0x1. Load tag 0x3 set 2 → mem write at 0x0000_0240 with the victim line. Then read at 0x0000_0640; total stall = 2 memory latencies + 3 cycles.
- Clean eviction: same sequence, victim not dirty → no mem write, only a read.
- Reset during FETCH: assert rst_i, then ack → no SRAM write, state IDLE, stall 0 with no request.
- Simultaneous read and write to a hit address → treated as store, cpu_data_o = 0.
